// File: rtl/fetch.sv
// Instruction fetch stage: credit-limited in-order word reads, a response FIFO feeding decode,
// and jump handling that flushes the FIFO and silently drops old-path responses still in flight.

module fetch_checker #(
  parameter int FETCH_BUF_SIZE = 4,
  parameter int CW             = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          resp_valid,
  input  logic [CW-1:0] ot_cnt,
  input  logic [CW-1:0] fifo_cnt,
  input  logic [CW-1:0] discard_cnt
);
  a_no_ot_underflow: assert property (@(posedge clk) disable iff (rst)
    resp_valid |-> (ot_cnt != '0));
  a_discard_le_ot: assert property (@(posedge clk) disable iff (rst)
    discard_cnt <= ot_cnt);
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, ot_cnt} + {1'b0, fifo_cnt}) <= (CW+1)'(FETCH_BUF_SIZE));
endmodule

module fetch #(
  parameter int FETCH_BUF_SIZE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_reset_i,
  input  logic        jump_i,
  input  logic [31:0] pc_jump_i,
  output logic        instr_req_valid_o,
  input  logic        instr_req_ready_i,
  output logic [31:0] instr_req_addr_o,
  input  logic        instr_resp_valid_i,
  input  logic [31:0] instr_resp_data_i,
  input  logic        instr_resp_error_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_instr_o,
  output logic        fetch_err_o
);
  localparam int AW = $clog2(FETCH_BUF_SIZE);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   BUF_LIMIT = (CW+1)'(FETCH_BUF_SIZE);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [31:0]   pc_ff, pc_next, req_addr_ff, req_addr_next;
  logic          req_valid_ff, req_valid_next, stale_ff, stale_next;
  logic [CW-1:0] ot_cnt, ot_next, fifo_cnt, fifo_next, discard_cnt, discard_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [32:0]   fifo_mem [FETCH_BUF_SIZE];
  logic [32:0]   head;
  logic          req_fire, req_stall, push, pop, drop_old, stale_fire, has_credit;

  assign req_fire   = req_valid_ff && instr_req_ready_i;
  assign req_stall  = req_valid_ff && !instr_req_ready_i;
  assign drop_old   = instr_resp_valid_i && (discard_cnt != '0);
  assign stale_fire = req_fire && stale_ff;
  assign push       = instr_resp_valid_i && !jump_i && (discard_cnt == '0);
  assign pop        = fetch_valid_o && fetch_ready_i;
  assign head       = fifo_mem[rd_ptr];

  assign instr_req_valid_o = req_valid_ff;
  assign instr_req_addr_o  = req_addr_ff;
  assign fetch_valid_o     = (fifo_cnt != '0) && !jump_i;
  assign fetch_instr_o     = fetch_valid_o ? head[31:0] : 32'h0000_0000;
  assign fetch_err_o       = fetch_valid_o && head[32];

  // Next-state for counters, PC and the request register
  always_comb begin
    has_credit = 1'b0;

    if (req_fire && !instr_resp_valid_i) ot_next = ot_cnt + CNT_ONE;
    else if (!req_fire && instr_resp_valid_i) ot_next = ot_cnt - CNT_ONE;
    else ot_next = ot_cnt;

    if (jump_i) fifo_next = '0;
    else if (push && !pop) fifo_next = fifo_cnt + CNT_ONE;
    else if (!push && pop) fifo_next = fifo_cnt - CNT_ONE;
    else fifo_next = fifo_cnt;

    // A jump re-arms discard with everything in flight; a stale request adds one more when it goes out
    if (jump_i) discard_next = ot_next;
    else if (drop_old && !stale_fire) discard_next = discard_cnt - CNT_ONE;
    else if (!drop_old && stale_fire) discard_next = discard_cnt + CNT_ONE;
    else discard_next = discard_cnt;

    if (jump_i) stale_next = req_stall;
    else if (req_fire) stale_next = 1'b0;
    else stale_next = stale_ff;

    if (jump_i) pc_next = pc_jump_i;
    else if (req_fire && !stale_ff) pc_next = pc_ff + 32'd4;
    else pc_next = pc_ff;

    has_credit = ({1'b0, ot_next} + {1'b0, fifo_next}) < BUF_LIMIT;
    if (req_stall) begin
      req_valid_next = 1'b1;
      req_addr_next  = req_addr_ff;
    end else begin
      req_valid_next = has_credit;
      req_addr_next  = pc_next;
    end
  end

  // State registers and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_ff        <= pc_reset_i;
      req_addr_ff  <= pc_reset_i;
      req_valid_ff <= 1'b0;
      stale_ff     <= 1'b0;
      ot_cnt       <= '0;
      fifo_cnt     <= '0;
      discard_cnt  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      pc_ff        <= pc_next;
      req_addr_ff  <= req_addr_next;
      req_valid_ff <= req_valid_next;
      stale_ff     <= stale_next;
      ot_cnt       <= ot_next;
      fifo_cnt     <= fifo_next;
      discard_cnt  <= discard_next;
      if (jump_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= push ? wr_ptr + PTR_ONE : wr_ptr;
        rd_ptr <= pop  ? rd_ptr + PTR_ONE : rd_ptr;
      end
    end
  end

  // FIFO storage holds {error, data}; only accepted responses are written
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {instr_resp_error_i, instr_resp_data_i};
    else fifo_mem[wr_ptr] <= fifo_mem[wr_ptr];
  end

  fetch_checker #(.FETCH_BUF_SIZE(FETCH_BUF_SIZE), .CW(CW)) u_checker (
    .clk         (clk),
    .rst         (rst),
    .resp_valid  (instr_resp_valid_i),
    .ot_cnt      (ot_cnt),
    .fifo_cnt    (fifo_cnt),
    .discard_cnt (discard_cnt)
  );
endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order memory model with configurable latency, request-address and
// delivered-stream scoreboard, a cycle table for the basic flow, and directed jump/error cases.
module tb_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_reset_i, pc_jump_i, instr_req_addr_o, instr_resp_data_i, fetch_instr_o;
  logic        jump_i, instr_req_valid_o, instr_req_ready_i, instr_resp_valid_i;
  logic        instr_resp_error_i, fetch_valid_o, fetch_ready_i, fetch_err_o;

  fetch #(.FETCH_BUF_SIZE(4)) dut (
    .clk(clk), .rst(rst), .pc_reset_i(pc_reset_i), .jump_i(jump_i), .pc_jump_i(pc_jump_i),
    .instr_req_valid_o(instr_req_valid_o), .instr_req_ready_i(instr_req_ready_i),
    .instr_req_addr_o(instr_req_addr_o), .instr_resp_valid_i(instr_resp_valid_i),
    .instr_resp_data_i(instr_resp_data_i), .instr_resp_error_i(instr_resp_error_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_instr_o(fetch_instr_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } bus_t;
  typedef struct { logic rr; logic dr; logic ev; logic [31:0] ea; logic efv; logic [31:0] eaddr; } vec_t;

  bus_t        bus_q[$];
  vec_t        vt[14];
  int          n_cmp = 0, n_fail = 0;
  int          cyc, n_acc, n_deliv, n_err_deliv, lat_lo, lat_hi;
  logic        drv_ready, drv_dec_ready, drv_jump, stale_pend, prev_pending;
  logic [31:0] drv_jump_pc, err_addr, req_exp, exp_pc, stale_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge clk);
    rst = 1'b1; pc_reset_i = pc; jump_i = 1'b0; pc_jump_i = 32'h0;
    instr_req_ready_i = 1'b0; instr_resp_valid_i = 1'b0; instr_resp_data_i = 32'h0;
    instr_resp_error_i = 1'b0; fetch_ready_i = 1'b0;
    bus_q.delete();
    cyc = 0; n_acc = 0; n_deliv = 0; n_err_deliv = 0;
    req_exp = pc; exp_pc = pc; stale_pend = 1'b0; prev_pending = 1'b0; drv_jump = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", instr_req_valid_o, 1'b0);
    chk("rst_req_addr", instr_req_addr_o, pc);
    chk("rst_fetch_valid", fetch_valid_o, 1'b0);
    chk("rst_fetch_instr", fetch_instr_o, 32'h0);
    chk("rst_fetch_err", fetch_err_o, 1'b0);
    rst = 1'b0;
  endtask

  task automatic drive_cycle();
    @(negedge clk);
    instr_req_ready_i = drv_ready;
    fetch_ready_i     = drv_dec_ready;
    jump_i            = drv_jump;
    pc_jump_i         = drv_jump_pc;
    instr_resp_valid_i = 1'b0; instr_resp_data_i = 32'h0; instr_resp_error_i = 1'b0;
    if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      instr_resp_valid_i = 1'b1;
      instr_resp_data_i  = mem_word(bus_q[0].addr);
      instr_resp_error_i = (bus_q[0].addr == err_addr);
      void'(bus_q.pop_front());
    end
    #1;
  endtask

  task automatic finish_cycle();
    if (prev_pending) chk("req_hold_valid", instr_req_valid_o, 1'b1);
    if (instr_req_valid_o && instr_req_ready_i) begin
      n_acc++;
      if (stale_pend) begin
        chk("stale_req_addr", instr_req_addr_o, stale_addr);
        stale_pend = 1'b0;
      end else begin
        chk("req_addr", instr_req_addr_o, req_exp);
        req_exp = req_exp + 32'd4;
      end
      bus_q.push_back('{instr_req_addr_o, cyc + 1 + int'($urandom_range(lat_hi, lat_lo))});
    end
    if (fetch_valid_o && fetch_ready_i) begin
      chk("deliver_instr", fetch_instr_o, mem_word(exp_pc));
      chk("deliver_err", fetch_err_o, (exp_pc == err_addr));
      if (fetch_err_o) n_err_deliv++;
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (jump_i) begin
      chk("jump_fetch_valid", fetch_valid_o, 1'b0);
      if (instr_req_valid_o && !instr_req_ready_i && !stale_pend) begin
        stale_pend = 1'b1;
        stale_addr = req_exp;
      end
      req_exp = pc_jump_i;
      exp_pc  = pc_jump_i;
    end
    prev_pending = instr_req_valid_o && !instr_req_ready_i;
    cyc++;
  endtask

  task automatic tick();
    drive_cycle();
    finish_cycle();
  endtask

  initial begin
    logic [31:0] b;
    int          w, d0;
    logic        got;
    b = 32'h8000_0000;
    vt[0]  = '{1'b1, 1'b1, 1'b1, b,            1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, b + 32'h04,   1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, b + 32'h08,   1'b1, b};
    vt[3]  = '{1'b1, 1'b0, 1'b1, b + 32'h0C,   1'b1, b + 32'h04};
    vt[4]  = '{1'b1, 1'b0, 1'b1, b + 32'h10,   1'b1, b + 32'h04};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, b + 32'h04};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, b + 32'h04};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, b + 32'h04};
    vt[8]  = '{1'b1, 1'b1, 1'b1, b + 32'h14,   1'b1, b + 32'h08};
    vt[9]  = '{1'b1, 1'b1, 1'b1, b + 32'h18,   1'b1, b + 32'h0C};
    vt[10] = '{1'b1, 1'b1, 1'b1, b + 32'h1C,   1'b1, b + 32'h10};
    vt[11] = '{1'b1, 1'b1, 1'b1, b + 32'h20,   1'b1, b + 32'h14};
    vt[12] = '{1'b1, 1'b1, 1'b1, b + 32'h24,   1'b1, b + 32'h18};
    vt[13] = '{1'b1, 1'b1, 1'b1, b + 32'h28,   1'b1, b + 32'h1C};

    rst = 1'b1; pc_reset_i = b; jump_i = 1'b0; pc_jump_i = 32'h0; instr_req_ready_i = 1'b0;
    instr_resp_valid_i = 1'b0; instr_resp_data_i = 32'h0; instr_resp_error_i = 1'b0;
    fetch_ready_i = 1'b0; cyc = 0;
    drv_ready = 1'b0; drv_dec_ready = 1'b1; drv_jump = 1'b0; drv_jump_pc = 32'h0;
    err_addr = 32'hFFFF_FFFF; lat_lo = 0; lat_hi = 0;

    // 1: sequential fetch with 1-cycle memory, short decode stall
    do_reset(b);
    for (int i = 0; i < 5 && !instr_req_valid_o; i++) tick();
    for (int k = 0; k < 14; k++) begin
      drv_ready = vt[k].rr; drv_dec_ready = vt[k].dr;
      drive_cycle();
      chk("t1_req_valid", instr_req_valid_o, vt[k].ev);
      if (vt[k].ev) chk("t1_req_addr", instr_req_addr_o, vt[k].ea);
      chk("t1_fetch_valid", fetch_valid_o, vt[k].efv);
      if (vt[k].efv) chk("t1_fetch_instr", fetch_instr_o, mem_word(vt[k].eaddr));
      finish_cycle();
    end

    // 2: decode blocked for 20 cycles
    do_reset(32'h0000_1000);
    drv_ready = 1'b1; drv_dec_ready = 1'b0;
    repeat (20) tick();
    chk("t2_req_count", n_acc, 4);
    chk("t2_req_idle", instr_req_valid_o, 1'b0);
    drv_dec_ready = 1'b1;
    repeat (12) tick();
    chk("t2_drained", (n_deliv >= 4), 1'b1);
    chk("t2_resumed", (n_acc > 4), 1'b1);

    // 3: jump with three requests in flight
    do_reset(b);
    lat_lo = 4; lat_hi = 4; drv_ready = 1'b1; drv_dec_ready = 1'b1;
    w = 0;
    while (bus_q.size() != 3 && w < 20) begin tick(); w++; end
    chk("t3_in_flight", bus_q.size(), 3);
    drv_jump = 1'b1; drv_jump_pc = 32'h0000_0100; tick(); drv_jump = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle();
      if (instr_req_valid_o && instr_req_ready_i && !got) begin
        chk("t3_new_addr", instr_req_addr_o, 32'h0000_0100);
        got = 1'b1;
      end
      finish_cycle();
    end
    chk("t3_new_req_seen", got, 1'b1);
    d0 = n_deliv;
    repeat (10) tick();
    chk("t3_delivered", (n_deliv > d0), 1'b1);

    // 4: jump while a request is stalled on the bus
    do_reset(32'h0000_0020);
    lat_lo = 0; lat_hi = 0; drv_ready = 1'b0; drv_dec_ready = 1'b1;
    repeat (3) tick();
    chk("t4_valid", instr_req_valid_o, 1'b1);
    chk("t4_addr", instr_req_addr_o, 32'h0000_0020);
    drv_jump = 1'b1; drv_jump_pc = 32'h0000_0200; tick(); drv_jump = 1'b0;
    repeat (3) tick();
    chk("t4_hold_valid", instr_req_valid_o, 1'b1);
    chk("t4_hold_addr", instr_req_addr_o, 32'h0000_0020);
    drv_ready = 1'b1; tick();
    drive_cycle();
    chk("t4_next_valid", instr_req_valid_o, 1'b1);
    chk("t4_next_addr", instr_req_addr_o, 32'h0000_0200);
    finish_cycle();
    repeat (15) tick();
    chk("t4_delivered", (n_deliv > 0), 1'b1);

    // 5: bus error on one word, plus one-cycle jump-to-request latency
    err_addr = 32'h0000_0044;
    do_reset(32'h0000_0030);
    drv_ready = 1'b1; drv_dec_ready = 1'b1;
    repeat (6) tick();
    drv_jump = 1'b1; drv_jump_pc = 32'h0000_0040; tick(); drv_jump = 1'b0;
    drive_cycle();
    chk("t5_jump_req_valid", instr_req_valid_o, 1'b1);
    chk("t5_jump_req_addr", instr_req_addr_o, 32'h0000_0040);
    finish_cycle();
    repeat (20) tick();
    chk("t5_err_count", n_err_deliv, 1);

    // 6: random stalls, latency and jumps, then quiesce
    do_reset(32'h0000_0000);
    lat_lo = 0; lat_hi = 5;
    for (int i = 0; i < 800; i++) begin
      drv_ready     = ($urandom_range(3, 0) != 0);
      drv_dec_ready = ($urandom_range(2, 0) != 0);
      drv_jump      = ($urandom_range(19, 0) == 0);
      drv_jump_pc   = $urandom & 32'h0000_FFFC;
      tick();
    end
    drv_jump = 1'b0; drv_ready = 1'b1; drv_dec_ready = 1'b0;
    repeat (60) tick();
    chk("t6_bus_idle", bus_q.size(), 0);
    chk("t6_req_idle", instr_req_valid_o, 1'b0);
    chk("t6_fifo_full", fetch_valid_o, 1'b1);
    drv_dec_ready = 1'b1;
    repeat (30) tick();
    chk("t6_delivered", (n_deliv > 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
